// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: converts byte-addressed RV32I loads/stores into word accesses
// on a word-wide data memory, with read-modify-write for sub-word stores.
module lsu_mem_ctrl #(
  parameter int unsigned MEM_WORDS = 60,
  parameter int unsigned ADDR_W    = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_func3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [2:0] {StIdle, StLoad, StWr, StRmwRd, StRmwWr, StResp} state_e;

  state_e              state_q, state_d;
  logic [2:0]          func3_q;
  logic [ADDR_W-1:0]   idx_q;
  logic [1:0]          off_q;
  logic [31:0]         wdata_q;
  logic [31:0]         merge_q;
  logic [31:0]         rdata_q;
  logic                err_q;

  logic [ADDR_W-1:0]   req_idx;
  logic                req_err;
  logic [31:0]         load_data;
  logic [31:0]         merged;

  assign req_idx   = req_addr[ADDR_W+1:2];
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  // Request legality, evaluated on the raw request at accept time
  always_comb begin
    logic hi_err, range_err, half_mis, word_mis, f3_err;
    hi_err    = (req_addr >> (ADDR_W + 2)) != 32'd0;
    range_err = 32'(req_idx) >= MEM_WORDS;
    half_mis  = (req_func3[1:0] == 2'b01) && req_addr[0];
    word_mis  = (req_func3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00);
    if (req_we) begin
      f3_err = req_func3[2] || (req_func3[1:0] == 2'b11);
    end else begin
      f3_err = (req_func3 == 3'b011) || (req_func3[2:1] == 2'b11);
    end
    req_err = hi_err || range_err || half_mis || word_mis || f3_err;
  end

  // Lane extraction and sign/zero extension of the load word
  always_comb begin
    logic [31:0] lane;
    lane = mem_rdata >> {off_q, 3'b000};
    case (func3_q)
      3'b000:  load_data = {{24{lane[7]}}, lane[7:0]};
      3'b001:  load_data = {{16{lane[15]}}, lane[15:0]};
      3'b100:  load_data = {24'd0, lane[7:0]};
      3'b101:  load_data = {16'd0, lane[15:0]};
      default: load_data = mem_rdata;
    endcase
  end

  // Sub-word store merge: replicate store data across lanes, then mask in the target lane
  always_comb begin
    logic [31:0] mask, data;
    if (func3_q[0]) begin
      mask = 32'h0000_FFFF << {off_q, 3'b000};
      data = {2{wdata_q[15:0]}};
    end else begin
      mask = 32'h0000_00FF << {off_q, 3'b000};
      data = {4{wdata_q[7:0]}};
    end
    merged = (merge_q & ~mask) | (data & mask);
  end

  // Next-state and state-decoded outputs
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_err)                      state_d = StResp;
          else if (!req_we)                 state_d = StLoad;
          else if (req_func3[1:0] == 2'b10) state_d = StWr;
          else                              state_d = StRmwRd;
        end
      end
      StLoad: begin
        mem_read = 1'b1;
        mem_addr = idx_q;
        state_d  = StResp;
      end
      StWr: begin
        mem_write = 1'b1;
        mem_addr  = idx_q;
        mem_wdata = wdata_q;
        state_d   = StResp;
      end
      StRmwRd: begin
        mem_read = 1'b1;
        mem_addr = idx_q;
        state_d  = StRmwWr;
      end
      StRmwWr: begin
        mem_write = 1'b1;
        mem_addr  = idx_q;
        mem_wdata = merged;
        state_d   = StResp;
      end
      StResp: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Request latches, merge word and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      func3_q <= 3'd0;
      idx_q   <= '0;
      off_q   <= 2'd0;
      wdata_q <= 32'd0;
      merge_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req_valid) begin
            func3_q <= req_func3;
            idx_q   <= req_idx;
            off_q   <= req_addr[1:0];
            wdata_q <= req_wdata;
            err_q   <= req_err;
            rdata_q <= 32'd0;
          end
        end
        StLoad:  rdata_q <= load_data;
        StRmwRd: merge_q <= mem_rdata;
        StResp: begin
          if (rsp_ready) begin
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
